// File: rtl/adpll_pkg.sv
// Shared ADPLL definitions: counter instruction codes and phase detector state encodings.
package adpll_pkg;

    // Instruction sent to the downstream up/down counter; 2'b11 is never produced.
    typedef enum logic [1:0] {
        INSTR_DISABLE    = 2'b00,
        INSTR_COUNT_UP   = 2'b01,
        INSTR_COUNT_DOWN = 2'b10
    } instr_e;

    // Phase detector states: idle, or waiting for the lagging clock edge.
    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        WAIT_DCO = 2'b01,
        WAIT_REF = 2'b10
    } pfd_state_e;

    // Moore decode from detector state to counter instruction.
    function automatic instr_e state_to_instr(input pfd_state_e st);
        case (st)
            WAIT_DCO: return INSTR_COUNT_UP;
            WAIT_REF: return INSTR_COUNT_DOWN;
            default:  return INSTR_DISABLE;
        endcase
    endfunction

endpackage

// File: rtl/pfd_instr_gen_if.sv
// Output bundle of the phase detector towards the counter / loop filter.
interface pfd_instr_gen_if #(
    parameter int unsigned WIDTH = 20
);
    logic [1:0]              count_instr_o;
    logic                    clear_o;
    logic signed [WIDTH-1:0] phase_err_o;
    logic                    err_valid_o;
    logic                    timeout_o;

    modport master (
        output count_instr_o,
        output clear_o,
        output phase_err_o,
        output err_valid_o,
        output timeout_o
    );

    modport slave (
        input count_instr_o,
        input clear_o,
        input phase_err_o,
        input err_valid_o,
        input timeout_o
    );
endinterface

// File: rtl/sync_rise_det.sv
// Multi-flop synchronizer for an asynchronous clock input followed by a rising-edge detector.
module sync_rise_det #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   hist_q;
    logic                   hist_d;

    // Shift the raw input into the chain; history holds the previous synchronized value.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_i};
        hist_d = sync_q[SYNC_STAGES-1];
    end

    // Synchronizer and history registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign rise_o = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/pfd_instr_gen.sv
// Phase/frequency detector: measures the gap between REF and DCO rising edges and
// drives up/down instructions plus a signed window length to the loop.
module pfd_instr_gen
    import adpll_pkg::*;
#(
    parameter int unsigned WIDTH       = 20,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned MAX_WAIT    = 1024
) (
    input  logic             fpga_clk_i,
    input  logic             reset_n_i,
    input  logic             enable_i,
    input  logic             ref_clk_i,
    input  logic             dco_clk_i,
    pfd_instr_gen_if.master  instr_if
);

    localparam logic [WIDTH-1:0] MAX_WAIT_W = WIDTH'(MAX_WAIT);

    logic ref_rise;
    logic dco_rise;

    pfd_state_e              state_q,     state_d;
    logic [WIDTH-1:0]        cnt_q,       cnt_d;
    logic signed [WIDTH-1:0] phase_err_q, phase_err_d;
    logic                    err_valid_q, err_valid_d;
    logic                    timeout_q,   timeout_d;
    logic                    enable_q,    enable_d;
    logic                    clear_q,     clear_d;

    sync_rise_det #(.SYNC_STAGES(SYNC_STAGES)) u_ref_det (
        .clk_i   (fpga_clk_i),
        .rst_ni  (reset_n_i),
        .async_i (ref_clk_i),
        .rise_o  (ref_rise)
    );

    sync_rise_det #(.SYNC_STAGES(SYNC_STAGES)) u_dco_det (
        .clk_i   (fpga_clk_i),
        .rst_ni  (reset_n_i),
        .async_i (dco_clk_i),
        .rise_o  (dco_rise)
    );

    // Next-state, window counter and result logic; closing rise has priority over timeout.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        phase_err_d = phase_err_q;
        err_valid_d = 1'b0;
        timeout_d   = 1'b0;
        enable_d    = enable_i;
        clear_d     = enable_i & ~enable_q;

        if (!enable_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (ref_rise && !dco_rise) begin
                        state_d = WAIT_DCO;
                        cnt_d   = WIDTH'(1);
                    end else if (dco_rise && !ref_rise) begin
                        state_d = WAIT_REF;
                        cnt_d   = WIDTH'(1);
                    end
                end
                WAIT_DCO: begin
                    if (dco_rise) begin
                        state_d     = IDLE;
                        cnt_d       = '0;
                        phase_err_d = $signed(cnt_q);
                        err_valid_d = 1'b1;
                    end else if (cnt_q == MAX_WAIT_W) begin
                        state_d   = IDLE;
                        cnt_d     = '0;
                        timeout_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + WIDTH'(1);
                    end
                end
                WAIT_REF: begin
                    if (ref_rise) begin
                        state_d     = IDLE;
                        cnt_d       = '0;
                        phase_err_d = -$signed(cnt_q);
                        err_valid_d = 1'b1;
                    end else if (cnt_q == MAX_WAIT_W) begin
                        state_d   = IDLE;
                        cnt_d     = '0;
                        timeout_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + WIDTH'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            phase_err_q <= '0;
            err_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            enable_q    <= 1'b0;
            clear_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            phase_err_q <= phase_err_d;
            err_valid_q <= err_valid_d;
            timeout_q   <= timeout_d;
            enable_q    <= enable_d;
            clear_q     <= clear_d;
        end
    end

    assign instr_if.count_instr_o = state_to_instr(state_q);
    assign instr_if.clear_o       = clear_q;
    assign instr_if.phase_err_o   = phase_err_q;
    assign instr_if.err_valid_o   = err_valid_q;
    assign instr_if.timeout_o     = timeout_q;

endmodule

// File: tb/tb_pfd_instr_gen.sv
// Testbench for pfd_instr_gen: directed scenarios plus random REF/DCO activity
// checked every cycle against an edge-index based window model.
module tb_pfd_instr_gen;

    localparam int WIDTH = 20;
    localparam int SYNC  = 2;
    localparam int MAXW  = 16;

    logic clk = 1'b0;
    logic rst_n;
    logic en;
    logic ref_c;
    logic dco_c;

    always #5 clk = ~clk;

    pfd_instr_gen_if #(.WIDTH(WIDTH)) pif ();

    pfd_instr_gen #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC),
        .MAX_WAIT    (MAXW)
    ) dut (
        .fpga_clk_i (clk),
        .reset_n_i  (rst_n),
        .enable_i   (en),
        .ref_clk_i  (ref_c),
        .dco_clk_i  (dco_c),
        .instr_if   (pif)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Model: raw samples per edge (newest first), open window start edge, last result.
    bit ref_smp[$];
    bit dco_smp[$];
    int m_mode;
    int m_open;
    int m_k;
    int m_phase;
    bit m_prev_en;

    // Per-scenario tallies of observed DUT behaviour.
    int n_up, n_down, n_ev, n_to;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ref_smp = {};
        dco_smp = {};
        for (int i = 0; i <= SYNC; i++) begin
            ref_smp.push_back(1'b0);
            dco_smp.push_back(1'b0);
        end
        m_mode    = 0;
        m_open    = 0;
        m_k       = 0;
        m_phase   = 0;
        m_prev_en = 1'b0;
    endtask

    task automatic clr_tally();
        n_up = 0; n_down = 0; n_ev = 0; n_to = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_instr"}, pif.count_instr_o, 0);
        chk({tag, "_clear"}, pif.clear_o, 0);
        chk({tag, "_phase"}, pif.phase_err_o, 0);
        chk({tag, "_valid"}, pif.err_valid_o, 0);
        chk({tag, "_tmo"},   pif.timeout_o, 0);
    endtask

    // One clock edge: advance the model from the sampled inputs, then compare all outputs.
    task automatic tick();
        bit rr, dr, closing, ev, to, clr;
        int len;
        logic signed [WIDTH-1:0] exp_phase;
        @(posedge clk);
        m_k++;
        // A rise is visible SYNC edges after the first high sample.
        rr = ref_smp[SYNC-1] && !ref_smp[SYNC];
        dr = dco_smp[SYNC-1] && !dco_smp[SYNC];
        ref_smp.push_front(ref_c);
        dco_smp.push_front(dco_c);
        void'(ref_smp.pop_back());
        void'(dco_smp.pop_back());
        ev  = 1'b0;
        to  = 1'b0;
        clr = en && !m_prev_en;
        m_prev_en = en;
        if (!en) begin
            m_mode = 0;
        end else if (m_mode == 0) begin
            if (rr && !dr) begin
                m_mode = 1; m_open = m_k;
            end else if (dr && !rr) begin
                m_mode = 2; m_open = m_k;
            end
        end else begin
            len     = m_k - m_open;
            closing = (m_mode == 1) ? dr : rr;
            if (closing) begin
                m_phase = (m_mode == 1) ? len : -len;
                ev      = 1'b1;
                m_mode  = 0;
            end else if (len == MAXW) begin
                to     = 1'b1;
                m_mode = 0;
            end
        end
        exp_phase = WIDTH'(m_phase);
        #1;
        chk("count_instr", pif.count_instr_o, m_mode);
        chk("clear",       pif.clear_o, clr);
        chk("phase_err",   pif.phase_err_o, exp_phase);
        chk("err_valid",   pif.err_valid_o, ev);
        chk("timeout",     pif.timeout_o, to);
        if (pif.count_instr_o == 2'b01) n_up++;
        if (pif.count_instr_o == 2'b10) n_down++;
        if (pif.err_valid_o) n_ev++;
        if (pif.timeout_o) n_to++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; ref_c = 1'b0; dco_c = 1'b0;
        model_reset();
        clr_tally();
        #1;
        chk_all_zero("reset");
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        run(3);

        // Enable rising: one-cycle clear pulse
        en = 1'b1;
        tick();
        chk("clear_pulse", pif.clear_o, 1);
        tick();
        chk("clear_end", pif.clear_o, 0);
        run(4);

        // REF leads DCO by 10 cycles
        clr_tally();
        ref_c = 1'b1; run(10);
        dco_c = 1'b1; run(6);
        chk("lead_up_cycles", n_up, 10);
        chk("lead_ev_count", n_ev, 1);
        chk("lead_phase", pif.phase_err_o, 10);
        ref_c = 1'b0; dco_c = 1'b0; run(4);

        // DCO leads REF by 7 cycles
        clr_tally();
        dco_c = 1'b1; run(7);
        ref_c = 1'b1; run(6);
        chk("lag_down_cycles", n_down, 7);
        chk("lag_ev_count", n_ev, 1);
        chk("lag_phase", pif.phase_err_o, -7);
        ref_c = 1'b0; dco_c = 1'b0; run(4);

        // Simultaneous rises from IDLE
        clr_tally();
        ref_c = 1'b1; dco_c = 1'b1; run(8);
        chk("both_busy_cycles", n_up + n_down, 0);
        chk("both_ev_count", n_ev, 0);
        ref_c = 1'b0; dco_c = 1'b0; run(4);

        // REF alone: window times out after MAXW cycles
        clr_tally();
        ref_c = 1'b1; run(25);
        chk("tmo_up_cycles", n_up, MAXW);
        chk("tmo_count", n_to, 1);
        chk("tmo_ev_count", n_ev, 0);
        chk("tmo_phase_kept", pif.phase_err_o, -7);
        ref_c = 1'b0; run(4);

        // Enable dropped mid-window
        ref_c = 1'b1; run(6);
        chk("en_in_window", pif.count_instr_o, 1);
        en = 1'b0; tick();
        chk("en_low_idle", pif.count_instr_o, 0);
        run(3);
        en = 1'b1; tick();
        chk("en_re_clear", pif.clear_o, 1);
        ref_c = 1'b0; run(4);

        // Reset asserted mid-window: outputs clear asynchronously
        dco_c = 1'b1; run(6);
        chk("rst_in_window", pif.count_instr_o, 2);
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        run(25);
        dco_c = 1'b0; run(4);

        // Random REF/DCO activity with occasional enable drops
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(5) == 0) ref_c = ~ref_c;
            if ($urandom_range(5) == 0) dco_c = ~dco_c;
            en = ($urandom_range(39) != 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
